ibex_instr_bus_responder: RTL and testbench

- Memory-side responder for the Ibex instruction fetch interface (req/gnt/rvalid/rdata/err).
- Accepts word-aligned fetch requests and reads a single-port SRAM with 1-cycle read latency.
- Returns in-order responses and flags out-of-range addresses as bus errors.
- Used in simulation and FPGA tops as the instruction memory behind the prefetch buffer; it is the producer side of the fetch FIFO input port.

---
 rtl/ibex_instr_bus_responder_pkg.sv | 21 ++
 rtl/ibex_instr_bus_responder_resp_fifo.sv | 74 +++++++
 rtl/ibex_instr_bus_responder.sv | 148 ++++++++++++++
 tb/tb_ibex_instr_bus_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_instr_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// ibex_instr_bus_responder_pkg
//   Shared types for the instruction-bus responder and its response FIFO.
//   instr_resp_t : one fetch response as returned to the core
//                  (rdata, err).
//   ptr_width()  : index width for a storage array of a given depth. It
//                  never returns less than 1, so a depth-1 FIFO still gets
//                  a legal pointer.
// ---------------------------------------------------------------------------
package ibex_instr_bus_responder_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } instr_resp_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ibex_instr_bus_responder_resp_fifo.sv
// ---------------------------------------------------------------------------
// ibex_instr_resp_fifo
//   Synchronous FIFO of instr_resp_t with a synchronous active-high reset.
//   Ports:
//     i_clk, i_rst     clock, synchronous active-high reset
//     i_push           write i_push_data this cycle
//     i_push_data      response to store
//     i_pop            drop the head entry this cycle (ignored when empty)
//     o_full, o_empty  occupancy flags
//     o_head           oldest entry (contents are undefined when empty)
//   A push and a pop in the same cycle are allowed when the FIFO is full.
// ---------------------------------------------------------------------------
module ibex_instr_resp_fifo
    import ibex_instr_bus_responder_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  instr_resp_t i_push_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output instr_resp_t o_head
);

    localparam int unsigned PW = ptr_width(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    instr_resp_t   r_mem [Depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(Depth));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only safe when the head leaves this cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Depth need not be a power of two, so the pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && o_full && !i_pop));

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// ---------------------------------------------------------------------------
// ibex_instr_bus_responder
//   Memory-side responder for the Ibex instruction fetch port. It grants
//   word-aligned fetches, reads a 1-cycle-latency single-port SRAM and
//   returns responses strictly in grant order. Addresses outside
//   [BaseAddr, BaseAddr + 4*MemWords) are answered with err=1, rdata=0.
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     instr_req_i        fetch request
//     instr_addr_i       byte address (bits [1:0] ignored)
//     instr_gnt_o        request accepted this cycle
//     instr_rvalid_o     single-cycle response pulse
//     instr_rdata_o      response data (0 when no response)
//     instr_err_o        response is a bus error (0 when no response)
//     resp_stall_i       hold responses in the FIFO while high
//     mem_req_o          SRAM read strobe
//     mem_addr_o         SRAM word index
//     mem_rdata_i        SRAM data, valid the cycle after mem_req_o
//
//   Handshake: a request transfers in every cycle where instr_req_i and
//   instr_gnt_o are both high. A response transfers in every cycle where
//   instr_rvalid_o is high; the core cannot push back. Flow control works
//   purely through the grant: at most MaxOutstanding requests may be granted
//   but not yet answered.
// ---------------------------------------------------------------------------
module ibex_instr_bus_responder
    import ibex_instr_bus_responder_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        resp_stall_i,
    output logic                        mem_req_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [31:0]                 mem_rdata_i
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    // Window size in bytes, one bit wider so it cannot wrap to zero.
    localparam logic [32:0] LP_SPAN = 33'(MemWords) << 2;

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic          w_gnt;
    logic [CW-1:0] r_outstanding;
    logic          r_inflight;
    logic          r_err_s1;
    instr_resp_t   w_s1;
    instr_resp_t   w_head;
    instr_resp_t   w_resp;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_rvalid;

    // Addresses below BaseAddr wrap to large offsets and fail the check.
    assign w_offset   = instr_addr_i - BaseAddr;
    assign w_in_range = ({1'b0, w_offset} < LP_SPAN);

    assign w_gnt       = instr_req_i & ~rst_i & (r_outstanding < CW'(MaxOutstanding));
    assign instr_gnt_o = w_gnt;
    assign mem_req_o   = w_gnt & w_in_range;
    assign mem_addr_o  = w_offset[AW+1:2];

    // S1 holds the response for the request granted in the previous cycle.
    assign w_s1.rdata = r_err_s1 ? 32'h0 : mem_rdata_i;
    assign w_s1.err   = r_err_s1;

    // The FIFO head is always older than S1. S1 bypasses only when nothing is
    // queued and responses are not stalled; otherwise it queues behind the head.
    always_comb begin
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_rvalid = 1'b0;
        w_resp   = '0;
        if (!rst_i) begin
            if (!w_fifo_empty) begin
                w_push = r_inflight;
                if (!resp_stall_i) begin
                    w_pop    = 1'b1;
                    w_rvalid = 1'b1;
                    w_resp   = w_head;
                end
            end else if (r_inflight) begin
                if (resp_stall_i) begin
                    w_push = 1'b1;
                end else begin
                    w_rvalid = 1'b1;
                    w_resp   = w_s1;
                end
            end
        end
    end

    assign instr_rvalid_o = w_rvalid;
    assign instr_rdata_o  = w_resp.rdata;
    assign instr_err_o    = w_resp.err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_inflight    <= 1'b0;
            r_err_s1      <= 1'b0;
        end else begin
            r_inflight <= w_gnt;
            r_err_s1   <= w_gnt & ~w_in_range;
            case ({w_gnt, w_rvalid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Every granted-but-unanswered request is either in S1 or in the FIFO,
    // so a FIFO of depth MaxOutstanding can never overflow.
    ibex_instr_resp_fifo #(
        .Depth(MaxOutstanding)
    ) u_resp_fifo (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_push     (w_push),
        .i_push_data(w_s1),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_head     (w_head)
    );

    a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        w_rvalid |-> (r_outstanding != '0));
    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_outstanding <= CW'(MaxOutstanding));
    a_fifo_push_ok: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
module tb_ibex_instr_bus_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MAX_OUT   = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    ibex_instr_bus_responder #(
        .MemWords      (MEM_WORDS),
        .BaseAddr      (BASE),
        .MaxOutstanding(MAX_OUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o (rdata),
        .instr_err_o   (err),
        .resp_stall_i  (stall),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata)
    );

    // SRAM with one cycle of read latency.
    logic [31:0] sram [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= sram[mem_addr];
    end

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds {err, rdata} for every granted, unanswered request, oldest first.
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic        exp_gnt;
    logic [45:0] exp_vec;
    logic [45:0] obs_vec;

    function automatic logic [32:0] model_resp(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off / 4 < MEM_WORDS) return {1'b0, sram[off / 4]};
        return {1'b1, 32'h0};
    endfunction

    function automatic string fmt(input logic [45:0] v);
        return $sformatf("gnt=%b mreq=%b maddr=%0d rvalid=%b err=%b rdata=%h",
                         v[45], v[44], v[43:34], v[33], v[32], v[31:0]);
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, advance the model
    // at the following posedge.
    task automatic drive_cycle(input logic r, input logic [31:0] a, input logic s);
        logic [31:0] off;
        logic        e_mreq;
        logic [9:0]  e_maddr;
        logic        e_rv;
        logic [32:0] e_resp;
        @(negedge clk);
        req   = r;
        addr  = a;
        stall = s;
        #1;
        off     = a - BASE;
        exp_gnt = r && (exp_q.size() < MAX_OUT);
        e_mreq  = exp_gnt && (off / 4 < MEM_WORDS);
        e_maddr = e_mreq ? 10'(off / 4) : 10'd0;
        e_rv    = !s && (exp_q.size() > 0);
        e_resp  = e_rv ? exp_q[0] : 33'h0;
        exp_vec = {exp_gnt, e_mreq, e_maddr, e_rv, e_resp};
        obs_vec = {gnt, mem_req, (mem_req ? mem_addr : 10'd0), rvalid, err, rdata};
        @(posedge clk);
        if (e_rv) void'(exp_q.pop_front());
        if (exp_gnt) exp_q.push_back(model_resp(a));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = 1'b1;
        addr  = 32'h10;
        stall = 1'b0;
        #1;
        checks++;
        if ({gnt, mem_req, rvalid, err, rdata} !== 36'h0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%b mreq=%b rvalid=%b err=%b rdata=%h, want all 0",
                     gnt, mem_req, rvalid, err, rdata);
        end
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
    endtask

    task automatic test_single();
        sram[4] = 32'hDEAD_BEEF;
        drive_cycle(1'b1, 32'h10, 1'b0);
        checks++;
        if (obs_vec !== exp_vec || obs_vec[45:34] !== {1'b1, 1'b1, 10'd4}) begin
            fails++;
            $display("FAIL single_grant: got %s, want %s", fmt(obs_vec), fmt(exp_vec));
        end
        drive_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_vec !== exp_vec || obs_vec[33:0] !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL single_resp: got %s, want %s", fmt(obs_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_back_to_back();
        int nrv = 0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(k < 3, 32'(4 * k), 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
            if (obs_vec[33]) nrv++;
        end
        checks++;
        if (nrv !== 3) begin
            fails++;
            $display("FAIL back_to_back_count: got %0d responses, want 3", nrv);
        end
    endtask

    task automatic test_out_of_range();
        drive_cycle(1'b1, BASE + 32'(4 * MEM_WORDS), 1'b0);
        checks++;
        if (obs_vec !== exp_vec || obs_vec[45:44] !== 2'b10) begin
            fails++;
            $display("FAIL oor_grant: got %s, want %s", fmt(obs_vec), fmt(exp_vec));
        end
        drive_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_vec !== exp_vec || obs_vec[33:0] !== {1'b1, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL oor_resp: got %s, want %s", fmt(obs_vec), fmt(exp_vec));
        end
    endtask

    task automatic test_stall();
        int ngnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b1, 32'(32'h100 + 4 * k), k < 4);
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL stall cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
            if (k < 4 && obs_vec[45]) ngnt++;
        end
        checks++;
        if (ngnt !== MAX_OUT) begin
            fails++;
            $display("FAIL stall_grants: got %0d grants while stalled, want %0d", ngnt, MAX_OUT);
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_mixed();
        logic [31:0] addrs [3];
        logic [2:0]  errs = 3'b000;
        int          idx  = 0;
        int          nrv  = 0;
        addrs = '{32'h20, 32'h2000, 32'h24};
        sram[8] = 32'h1111_2222;
        sram[9] = 32'h3333_4444;
        for (int k = 0; k < 10; k++) begin
            drive_cycle(idx < 3, addrs[(idx < 3) ? idx : 0], k == 1);
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL mixed cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
            if (exp_gnt) idx++;
            if (obs_vec[33]) begin
                errs = {errs[1:0], obs_vec[32]};
                nrv++;
            end
        end
        checks++;
        if (errs !== 3'b010 || nrv !== 3) begin
            fails++;
            $display("FAIL mixed_err_seq: got %b (%0d responses), want 010 (3 responses)", errs, nrv);
        end
    endtask

    task automatic test_reset_midflight();
        int nrv = 0;
        drive_cycle(1'b1, 32'h40, 1'b1);
        drive_cycle(1'b1, 32'h44, 1'b1);
        test_reset();
        // Dropped requests must never be answered.
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 32'h0, 1'b0);
            if (obs_vec[33]) nrv++;
        end
        checks++;
        if (nrv !== 0) begin
            fails++;
            $display("FAIL reset_dropped: got %0d stale responses, want 0", nrv);
        end
        drive_cycle(1'b1, 32'h48, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_vec !== exp_vec || obs_vec[33:0] !== {1'b1, 1'b0, sram[18]}) begin
            fails++;
            $display("FAIL reset_first_resp: got %s, want %s", fmt(obs_vec), fmt(exp_vec));
        end
        // With the count back at zero exactly MAX_OUT stalled grants fit.
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 32'(32'h50 + 4 * k), 1'b1);
            checks++;
            if (obs_vec !== exp_vec || obs_vec[45] !== (k < MAX_OUT)) begin
                fails++;
                $display("FAIL reset_count cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
                1:       a = BASE + 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 65535));
                default: a = BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1));
            endcase
            drive_cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) == 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 32'h0, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random_drain cycle %0d: got %s, want %s", k, fmt(obs_vec), fmt(exp_vec));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        addr      = 32'h0;
        stall     = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) sram[i] = $urandom();
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_stall();
        test_mixed();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
